// File: rtl/adder_sweep_checker.sv
// rtl/adder_sweep_checker.sv - exhaustive operand sweep and result checker for an extended-carry adder
//
// Purpose: on START, walks every {A,B} operand pair in ascending order, holds each
// pair for SETTLE_CYCLES, then samples SUM_IN against the exact A+B. Reports the
// mismatch count and the first failing vector.
//
// Ports:
//   clk           rising-edge system clock
//   rst_n         synchronous active-low reset
//   START         begins a sweep when sampled high in IDLE or DONE
//   A_OUT, B_OUT  operands to the adder (high / low field of the vector index)
//   SUM_IN        adder result, WIDTH+1 bits
//   BUSY          sweep in progress (SETTLE or CHECK)
//   DONE, PASS    sweep finished / finished with zero mismatches
//   ERR_COUNT     number of mismatching vectors
//   FIRST_ERR_*   A, B and SUM_IN of the first mismatch
module adder_sweep_checker #(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               START,
  output logic [WIDTH-1:0]   A_OUT,
  output logic [WIDTH-1:0]   B_OUT,
  input  logic [WIDTH:0]     SUM_IN,
  output logic               BUSY,
  output logic               DONE,
  output logic               PASS,
  output logic [2*WIDTH:0]   ERR_COUNT,
  output logic [WIDTH-1:0]   FIRST_ERR_A,
  output logic [WIDTH-1:0]   FIRST_ERR_B,
  output logic [WIDTH:0]     FIRST_ERR_SUM
);

  // A settle time of 0 would leave no cycle for the adder to respond; clamp to 1.
  localparam int SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam int CW         = $clog2(SETTLE_EFF + 1);
  localparam int IW         = 2 * WIDTH;
  localparam int EW         = 2 * WIDTH + 1;
  localparam int SW         = WIDTH + 1;

  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_EFF);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t           state_q;
  logic [IW-1:0]    idx_q;
  logic [CW-1:0]    cnt_q;
  logic             err_seen_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [EW-1:0]    err_count_q;
  logic [WIDTH-1:0] first_a_q;
  logic [WIDTH-1:0] first_b_q;
  logic [SW-1:0]    first_sum_q;

  logic [WIDTH-1:0] a_cur;
  logic [WIDTH-1:0] b_cur;
  logic [SW-1:0]    expected_sum;
  logic             mismatch;
  logic [EW-1:0]    err_count_d;
  logic             idx_last;

  always_comb begin
    a_cur        = idx_q[IW-1:WIDTH];
    b_cur        = idx_q[WIDTH-1:0];
    // Zero-extend both operands so the carry-out lands in the top bit.
    expected_sum = {1'b0, a_cur} + {1'b0, b_cur};
    mismatch     = (SUM_IN != expected_sum);
    err_count_d  = err_count_q + {{(EW-1){1'b0}}, mismatch};
    idx_last     = &idx_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      err_seen_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_count_q <= '0;
      first_a_q   <= '0;
      first_b_q   <= '0;
      first_sum_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (START) begin
            state_q     <= ST_SETTLE;
            idx_q       <= '0;
            cnt_q       <= SETTLE_LOAD;
            err_seen_q  <= 1'b0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_count_q <= '0;
            first_a_q   <= '0;
            first_b_q   <= '0;
            first_sum_q <= '0;
          end
        end

        ST_SETTLE: begin
          // The counter is loaded with the settle length, so leaving on 1
          // gives exactly SETTLE_EFF settle cycles plus the CHECK cycle.
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_q <= ST_CHECK;
          end
        end

        ST_CHECK: begin
          if (mismatch) begin
            err_count_q <= err_count_d;
            if (!err_seen_q) begin
              err_seen_q  <= 1'b1;
              first_a_q   <= a_cur;
              first_b_q   <= b_cur;
              first_sum_q <= SUM_IN;
            end
          end
          if (idx_last) begin
            // Operands stay on the last vector until the next START.
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_count_d == '0);
          end else begin
            state_q <= ST_SETTLE;
            idx_q   <= idx_q + IW'(1);
            cnt_q   <= SETTLE_LOAD;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          pass_q  <= 1'b0;
        end
      endcase
    end
  end

  assign A_OUT         = idx_q[IW-1:WIDTH];
  assign B_OUT         = idx_q[WIDTH-1:0];
  assign BUSY          = busy_q;
  assign DONE          = done_q;
  assign PASS          = pass_q;
  assign ERR_COUNT     = err_count_q;
  assign FIRST_ERR_A   = first_a_q;
  assign FIRST_ERR_B   = first_b_q;
  assign FIRST_ERR_SUM = first_sum_q;

endmodule

// File: tb/tb_adder_sweep_checker.sv
// tb/tb_adder_sweep_checker.sv - self-checking bench for adder_sweep_checker
module tb_adder_sweep_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start, start3, start0;
  logic [3:0] a_out, b_out, a3, b3, a0, b0;
  logic [4:0] sum_in, sum3, sum0;
  logic       busy, done, pass, busy3, done3, pass3, busy0, done0, pass0;
  logic [8:0] err_count, ec3, ec0;
  logic [3:0] fa, fb, fa3, fb3, fa0, fb0;
  logic [4:0] fs, fs3, fs0;

  int errors = 0;
  int checks = 0;

  // Adder behaviour seen by the main DUT: 0 ideal, 1 bit4 stuck 0,
  // 2 bit0 stuck 1, 3 random per-vector corruption.
  int         mode = 0;
  logic [4:0] corrupt [256];

  function automatic logic [4:0] adder_model(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b};
    case (mode)
      1:       adder_model = s & 5'h0F;
      2:       adder_model = s | 5'h01;
      3:       adder_model = s ^ corrupt[{a, b}];
      default: adder_model = s;
    endcase
  endfunction

  always_comb sum_in = adder_model(a_out, b_out);
  assign sum3 = {1'b0, a3} + {1'b0, b3};
  assign sum0 = {1'b0, a0} + {1'b0, b0};

  adder_sweep_checker #(.WIDTH(4), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .START(start), .A_OUT(a_out), .B_OUT(b_out),
    .SUM_IN(sum_in), .BUSY(busy), .DONE(done), .PASS(pass), .ERR_COUNT(err_count),
    .FIRST_ERR_A(fa), .FIRST_ERR_B(fb), .FIRST_ERR_SUM(fs));

  adder_sweep_checker #(.WIDTH(4), .SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .START(start3), .A_OUT(a3), .B_OUT(b3),
    .SUM_IN(sum3), .BUSY(busy3), .DONE(done3), .PASS(pass3), .ERR_COUNT(ec3),
    .FIRST_ERR_A(fa3), .FIRST_ERR_B(fb3), .FIRST_ERR_SUM(fs3));

  adder_sweep_checker #(.WIDTH(4), .SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .START(start0), .A_OUT(a0), .B_OUT(b0),
    .SUM_IN(sum0), .BUSY(busy0), .DONE(done0), .PASS(pass0), .ERR_COUNT(ec0),
    .FIRST_ERR_A(fa0), .FIRST_ERR_B(fb0), .FIRST_ERR_SUM(fs0));

  // Reference: walk all operand pairs, compare what the adder model returns
  // against true integer addition, remember the first disagreement.
  task automatic model_sweep(output int cnt, output logic [3:0] ea,
                             output logic [3:0] eb, output logic [4:0] es);
    cnt = 0; ea = '0; eb = '0; es = '0;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        logic [4:0] got;
        got = adder_model(a[3:0], b[3:0]);
        if (int'(got) != a + b) begin
          if (cnt == 0) begin ea = a[3:0]; eb = b[3:0]; es = got; end
          cnt++;
        end
      end
    end
  endtask

  task automatic set_start(input int sel, input logic v);
    case (sel)
      1:       start3 = v;
      2:       start0 = v;
      default: start  = v;
    endcase
  endtask

  // Starts a sweep on the selected instance. lat = number of clock edges after
  // the START-sampling edge until DONE is first observed; verr counts cycles in
  // which the presented vector differs from n/(s+1). e0/f0 snapshot the main
  // DUT's results right after the START edge.
  task automatic run_sweep(input int sel, input int s, input bit pulses,
                           output int lat, output int verr,
                           output logic [8:0] e0, output logic [12:0] f0);
    int n;
    logic d;
    logic [7:0] v;
    lat = -1; verr = 0; n = 0;
    @(negedge clk); set_start(sel, 1'b1);
    @(negedge clk); set_start(sel, 1'b0);
    e0 = err_count; f0 = {fa, fb, fs};
    while (n < 3000) begin
      case (sel)
        1:       begin d = done3; v = {a3, b3}; end
        2:       begin d = done0; v = {a0, b0}; end
        default: begin d = done;  v = {a_out, b_out}; end
      endcase
      if (d) begin lat = n; break; end
      if (int'(v) != n / (s + 1)) verr++;
      if (pulses) start = ((n % 37) == 5) && (n < 480);
      @(negedge clk);
      n++;
    end
    set_start(sel, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; start3 = 1'b0; start0 = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({a_out, b_out, busy, done, pass, err_count, fa, fb, fs} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got a=%0d b=%0d busy=%0b done=%0b pass=%0b err=%0d first=%0d/%0d/%0d want all 0",
               a_out, b_out, busy, done, pass, err_count, fa, fb, fs);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, a_out, b_out} !== '0) begin
      errors++;
      $display("FAIL idle_no_start: got busy=%0b done=%0b a=%0d b=%0d want 0", busy, done, a_out, b_out);
    end
  endtask

  task automatic test_good_sweep();
    int lat, verr, ec; logic [3:0] ea, eb; logic [4:0] es; logic [8:0] e0; logic [12:0] f0;
    mode = 0;
    model_sweep(ec, ea, eb, es);
    run_sweep(0, 1, 1'b0, lat, verr, e0, f0);
    checks++; if (lat !== 512) begin errors++; $display("FAIL good_latency: got %0d want 512", lat); end
    checks++; if (verr !== 0) begin errors++; $display("FAIL good_vector_order: got %0d bad cycles want 0", verr); end
    checks++;
    if ({pass, busy, err_count} !== {1'b1, 1'b0, 9'(ec)}) begin
      errors++; $display("FAIL good_result: got pass=%0b busy=%0b err=%0d want pass=1 busy=0 err=%0d", pass, busy, err_count, ec);
    end
    checks++; if ({fa, fb, fs} !== 13'd0) begin errors++; $display("FAIL good_first_err: got %0d/%0d/%0d want 0/0/0", fa, fb, fs); end
    repeat (5) @(negedge clk);
    checks++;
    if ({done, pass, a_out, b_out} !== {2'b11, 4'd15, 4'd15}) begin
      errors++; $display("FAIL good_hold: got done=%0b pass=%0b a=%0d b=%0d want 1 1 15 15", done, pass, a_out, b_out);
    end
  endtask

  task automatic test_fault(input int m, input string name);
    int lat, verr, ec; logic [3:0] ea, eb; logic [4:0] es; logic [8:0] e0; logic [12:0] f0;
    mode = m;
    model_sweep(ec, ea, eb, es);
    run_sweep(0, 1, 1'b0, lat, verr, e0, f0);
    checks++; if (lat !== 512) begin errors++; $display("FAIL %s_latency: got %0d want 512", name, lat); end
    checks++;
    if (err_count !== 9'(ec)) begin errors++; $display("FAIL %s_err_count: got %0d want %0d", name, err_count, ec); end
    checks++;
    if ({fa, fb, fs} !== {ea, eb, es}) begin
      errors++; $display("FAIL %s_first_err: got %0d/%0d/%0d want %0d/%0d/%0d", name, fa, fb, fs, ea, eb, es);
    end
    checks++;
    if ({done, pass} !== {1'b1, (ec == 0)}) begin
      errors++; $display("FAIL %s_pass: got done=%0b pass=%0b want done=1 pass=%0b", name, done, pass, ec == 0);
    end
  endtask

  task automatic test_random_faults();
    for (int i = 0; i < 256; i++) corrupt[i] = '0;
    corrupt[$urandom_range(40, 255)] = 5'($urandom_range(1, 31));
    for (int i = 0; i < 6; i++) corrupt[$urandom_range(0, 255)] = 5'($urandom_range(0, 31));
    test_fault(3, "random");
  endtask

  task automatic test_back_to_back();
    int lat, verr, ec; logic [3:0] ea, eb; logic [4:0] es; logic [8:0] e0; logic [12:0] f0;
    mode = 1;
    model_sweep(ec, ea, eb, es);
    run_sweep(0, 1, 1'b1, lat, verr, e0, f0);
    checks++; if (lat !== 512) begin errors++; $display("FAIL b2b_pulsed_latency: got %0d want 512", lat); end
    checks++; if (verr !== 0) begin errors++; $display("FAIL b2b_pulsed_order: got %0d bad cycles want 0", verr); end
    checks++;
    if ({err_count, fa, fb, fs} !== {9'(ec), ea, eb, es}) begin
      errors++; $display("FAIL b2b_pulsed_result: got err=%0d first=%0d/%0d/%0d want %0d %0d/%0d/%0d",
                         err_count, fa, fb, fs, ec, ea, eb, es);
    end
    mode = 0;
    run_sweep(0, 1, 1'b0, lat, verr, e0, f0);
    checks++;
    if ({e0, f0} !== 22'd0) begin errors++; $display("FAIL b2b_restart_clear: got err=%0d first=%0h want 0 0", e0, f0); end
    checks++; if (lat !== 512) begin errors++; $display("FAIL b2b_restart_latency: got %0d want 512", lat); end
    checks++;
    if ({pass, err_count} !== {1'b1, 9'd0}) begin errors++; $display("FAIL b2b_restart_pass: got pass=%0b err=%0d want 1 0", pass, err_count); end
  endtask

  task automatic test_reset_mid_sweep();
    int lat, verr, n; logic [8:0] e0; logic [12:0] f0;
    mode = 2;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (({a_out, b_out} != 8'd100) && (n < 2000)) begin @(negedge clk); n++; end
    checks++; if (n >= 2000) begin errors++; $display("FAIL mid_reach_idx100: got timeout want idx=100"); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({a_out, b_out, busy, done, pass, err_count, fa, fb, fs} !== '0) begin
      errors++; $display("FAIL mid_reset_outputs: got a=%0d b=%0d busy=%0b done=%0b err=%0d first=%0d/%0d/%0d want all 0",
                         a_out, b_out, busy, done, err_count, fa, fb, fs);
    end
    repeat (4) @(negedge clk);
    checks++;
    if ({busy, done, a_out, b_out} !== '0) begin errors++; $display("FAIL mid_stays_idle: got busy=%0b done=%0b a=%0d b=%0d want 0", busy, done, a_out, b_out); end
    mode = 0;
    run_sweep(0, 1, 1'b0, lat, verr, e0, f0);
    checks++;
    if ({lat == 512, pass} !== 2'b11) begin errors++; $display("FAIL mid_fresh_sweep: got lat=%0d pass=%0b want 512 1", lat, pass); end
  endtask

  task automatic test_settle_cycles();
    int lat, verr; logic [8:0] e0; logic [12:0] f0;
    run_sweep(1, 3, 1'b0, lat, verr, e0, f0);
    checks++; if (lat !== 1024) begin errors++; $display("FAIL settle3_latency: got %0d want 1024", lat); end
    checks++; if (verr !== 0) begin errors++; $display("FAIL settle3_hold: got %0d bad cycles want 0", verr); end
    checks++;
    if ({pass3, ec3} !== {1'b1, 9'd0}) begin errors++; $display("FAIL settle3_pass: got pass=%0b err=%0d want 1 0", pass3, ec3); end
    run_sweep(2, 1, 1'b0, lat, verr, e0, f0);
    checks++; if (lat !== 512) begin errors++; $display("FAIL settle0_latency: got %0d want 512", lat); end
    checks++; if (verr !== 0) begin errors++; $display("FAIL settle0_hold: got %0d bad cycles want 0", verr); end
    checks++;
    if ({pass0, ec0} !== {1'b1, 9'd0}) begin errors++; $display("FAIL settle0_pass: got pass=%0b err=%0d want 1 0", pass0, ec0); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) corrupt[i] = '0;
    test_reset();
    test_good_sweep();
    test_fault(1, "bit4_stuck0");
    test_fault(2, "bit0_stuck1");
    test_random_faults();
    test_back_to_back();
    test_reset_mid_sweep();
    test_settle_cycles();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
